bram_dsp_seq_ctrl: RTL and testbench

Parametrised sequencer that drives a BRAM0/BRAM1 -> DSP48 -> BRAM1 datapath over a vector of LEN elements per command.
- Accepts one command through a valid/ready handshake.
- Issues one read pair per cycle at auto-incrementing addresses.
- Tracks elements through a fixed-latency pipeline and issues the matching BRAM1 write-backs.
- Pulses done when the last write retires.
- Sits between the host instruction interface and the BRAM/DSP primitives, replacing the single-shot fixed-timing controller.

---
 rtl/bram_dsp_seq_ctrl_pkg.sv | 30 +++
 rtl/bram_dsp_seq_ctrl_lat_pipe.sv | 62 ++++++
 rtl/bram_dsp_seq_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_bram_dsp_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_dsp_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bram_dsp_pkg
//   Shared types and constants for the BRAM -> DSP48 -> BRAM sequencers.
//   - state_t          : controller state encoding
//   - *_W              : DSP48 mode-field widths
//   - OPMODE_* / ALUMODE_* / INMODE_* : commonly used mode settings
// ---------------------------------------------------------------------------
package bram_dsp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int INMODE_W  = 5;
    localparam int OPMODE_W  = 7;
    localparam int ALUMODE_W = 4;

    // INMODE: A2/B2 paths, no pre-adder.
    localparam logic [INMODE_W-1:0]  INMODE_DEFAULT = 5'b00000;
    // OPMODE {Z[2:0], Y[1:0], X[1:0]}: X=Y=M gives P = A*B; Z=P accumulates.
    localparam logic [OPMODE_W-1:0]  OPMODE_MULT    = 7'b000_01_01;
    localparam logic [OPMODE_W-1:0]  OPMODE_MAC     = 7'b010_01_01;
    // ALUMODE: 0000 = Z+X+Y+CIN, 0011 = Z-(X+Y+CIN).
    localparam logic [ALUMODE_W-1:0] ALUMODE_ADD    = 4'b0000;
    localparam logic [ALUMODE_W-1:0] ALUMODE_SUB    = 4'b0011;

endpackage

// File: rtl/bram_dsp_seq_ctrl_lat_pipe.sv
// ---------------------------------------------------------------------------
// lat_pipe
//   DEPTH-deep shift register carrying {valid, index} for elements in flight
//   through a fixed-latency datapath. An input presented in cycle t appears on
//   the output in cycle t+DEPTH. flush clears every stage on the next edge.
// Ports:
//   clk       : clock
//   reset     : asynchronous, active-low reset
//   flush     : synchronous clear of all stages (wins over in_valid)
//   in_valid  : element entering the pipe this cycle
//   in_index  : element index
//   out_valid : element leaving the pipe this cycle
//   out_index : index of the leaving element
// ---------------------------------------------------------------------------
module lat_pipe #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_index,
    output logic         out_valid,
    output logic [W-1:0] out_index
);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic         valid_reg;
            logic [W-1:0] index_reg;
            logic         valid_next;
            logic [W-1:0] index_next;

            if (gi == 0) begin : g_head
                assign valid_next = in_valid;
                assign index_next = in_index;
            end else begin : g_tail
                assign valid_next = g_stage[gi-1].valid_reg;
                assign index_next = g_stage[gi-1].index_reg;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg <= 1'b0;
                    index_reg <= '0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                    index_reg <= '0;
                end else begin
                    valid_reg <= valid_next;
                    index_reg <= index_next;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[DEPTH-1].valid_reg;
    assign out_index = g_stage[DEPTH-1].index_reg;

endmodule

// File: rtl/bram_dsp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bram_dsp_seq_ctrl
//   Vector sequencer for a BRAM0/BRAM1 -> DSP48 -> BRAM1 datapath. Accepts one
//   command, issues one read pair per cycle at auto-incrementing addresses,
//   tracks each element through a PIPE_LAT-deep pipe and issues the matching
//   BRAM1 write-back, then pulses done.
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//   cmd_src0/src1/dst/len      : base addresses and element count (0 legal)
//   cmd_inmode/opmode/alumode  : DSP modes, latched on accept
//   abort                      : synchronous cancel while busy
//   busy, done                 : status; done is a one-cycle pulse
//   bram0_addr, bram1_raddr    : registered read addresses
//   bram1_waddr, bram1_we      : write-back address / byte enables
//   dsp_inmode/opmode/alumode  : latched modes of the current command
// ---------------------------------------------------------------------------
module bram_dsp_seq_ctrl
    import bram_dsp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int LEN_W       = 8,
    parameter int WE_W        = 4,
    parameter int BRAM_RD_LAT = 1,
    parameter int DSP_LAT     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_src0,
    input  logic [ADDR_W-1:0]    cmd_src1,
    input  logic [ADDR_W-1:0]    cmd_dst,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic [INMODE_W-1:0]  cmd_inmode,
    input  logic [OPMODE_W-1:0]  cmd_opmode,
    input  logic [ALUMODE_W-1:0] cmd_alumode,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    bram0_addr,
    output logic [ADDR_W-1:0]    bram1_raddr,
    output logic [ADDR_W-1:0]    bram1_waddr,
    output logic [WE_W-1:0]      bram1_we,
    output logic [INMODE_W-1:0]  dsp_inmode,
    output logic [OPMODE_W-1:0]  dsp_opmode,
    output logic [ALUMODE_W-1:0] dsp_alumode
);

    localparam int PIPE_LAT = BRAM_RD_LAT + DSP_LAT;
    localparam logic [LEN_W-1:0]  ONE_LEN  = 1;
    localparam logic [ADDR_W-1:0] ONE_ADDR = 1;

    state_t                 state_reg,   state_next;
    logic [LEN_W-1:0]       idx_reg,     idx_next;
    logic [LEN_W-1:0]       len_reg,     len_next;
    logic [ADDR_W-1:0]      rd0_reg,     rd0_next;
    logic [ADDR_W-1:0]      rd1_reg,     rd1_next;
    logic [ADDR_W-1:0]      dst_reg,     dst_next;
    logic [INMODE_W-1:0]    inmode_reg,  inmode_next;
    logic [OPMODE_W-1:0]    opmode_reg,  opmode_next;
    logic [ALUMODE_W-1:0]   alumode_reg, alumode_next;

    logic                   accept;
    logic                   push_valid;
    logic                   flush;
    logic                   pipe_valid;
    logic [LEN_W-1:0]       pipe_index;
    logic                   last_issue;
    logic                   last_write;
    logic                   wr_active;

    assign accept     = cmd_valid && (state_reg == ST_IDLE);
    assign last_issue = (idx_reg == (len_reg - ONE_LEN));
    // The pipe delivers indices in issue order, so the last index leaving it
    // is the final write of the command.
    assign last_write = pipe_valid && (pipe_index == (len_reg - ONE_LEN));

    // ---------------------------------------------------------------------
    // Next-state and datapath-register logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        len_next     = len_reg;
        rd0_next     = rd0_reg;
        rd1_next     = rd1_reg;
        dst_next     = dst_reg;
        inmode_next  = inmode_reg;
        opmode_next  = opmode_reg;
        alumode_next = alumode_reg;
        push_valid   = 1'b0;
        flush        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // abort is ignored here, so a simultaneous command still lands.
                if (accept) begin
                    idx_next     = '0;
                    len_next     = cmd_len;
                    rd0_next     = cmd_src0;
                    rd1_next     = cmd_src1;
                    dst_next     = cmd_dst;
                    inmode_next  = cmd_inmode;
                    opmode_next  = cmd_opmode;
                    alumode_next = cmd_alumode;
                    state_next   = (cmd_len == '0) ? ST_DONE : ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    // Element idx_reg's addresses are on the bus this cycle.
                    push_valid = 1'b1;
                    if (last_issue) begin
                        // Read addresses hold the last element's values.
                        state_next = ST_DRAIN;
                    end else begin
                        idx_next = idx_reg + ONE_LEN;
                        rd0_next = rd0_reg + ONE_ADDR;
                        rd1_next = rd1_reg + ONE_ADDR;
                    end
                end
            end

            ST_DRAIN: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = ST_IDLE;
                end else if (last_write) begin
                    state_next = ST_DONE;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            len_reg     <= '0;
            rd0_reg     <= '0;
            rd1_reg     <= '0;
            dst_reg     <= '0;
            inmode_reg  <= '0;
            opmode_reg  <= '0;
            alumode_reg <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            len_reg     <= len_next;
            rd0_reg     <= rd0_next;
            rd1_reg     <= rd1_next;
            dst_reg     <= dst_next;
            inmode_reg  <= inmode_next;
            opmode_reg  <= opmode_next;
            alumode_reg <= alumode_next;
        end
    end

    // ---------------------------------------------------------------------
    // Element tracking: one stage per cycle of BRAM read + DSP latency
    // ---------------------------------------------------------------------
    lat_pipe #(
        .DEPTH (PIPE_LAT),
        .W     (LEN_W)
    ) u_lat_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (push_valid),
        .in_index  (idx_reg),
        .out_valid (pipe_valid),
        .out_index (pipe_index)
    );

    // ---------------------------------------------------------------------
    // Outputs. Write strobes derive from reset-cleared registers, so reset
    // forces we low without waiting for a clock edge.
    // ---------------------------------------------------------------------
    assign wr_active   = pipe_valid && ((state_reg == ST_ISSUE) || (state_reg == ST_DRAIN));
    assign bram1_we    = wr_active ? {WE_W{1'b1}} : {WE_W{1'b0}};
    assign bram1_waddr = wr_active ? (dst_reg + ADDR_W'(pipe_index)) : '0;

    assign bram0_addr  = rd0_reg;
    assign bram1_raddr = rd1_reg;
    assign dsp_inmode  = inmode_reg;
    assign dsp_opmode  = opmode_reg;
    assign dsp_alumode = alumode_reg;

    assign cmd_ready   = (state_reg == ST_IDLE);
    assign busy        = (state_reg == ST_ISSUE) || (state_reg == ST_DRAIN);
    assign done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_bram_dsp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bram_dsp_seq_ctrl
//   Directed bench for bram_dsp_seq_ctrl. u_dut uses default latencies
//   (PIPE_LAT = 4); u_dut_b uses BRAM_RD_LAT=2, DSP_LAT=4 (PIPE_LAT = 6).
//   Cycle c = number of rising edges since the accept edge (accept edge -> c=1).
// ---------------------------------------------------------------------------
module tb_bram_dsp_seq_ctrl;
    import bram_dsp_pkg::*;

    localparam int PL   = 4;
    localparam int PL_B = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // ---- DUT A (default parameters) ----
    logic        cmd_valid, cmd_ready, abort, busy, done;
    logic [9:0]  cmd_src0, cmd_src1, cmd_dst;
    logic [7:0]  cmd_len;
    logic [4:0]  cmd_inmode, dsp_inmode;
    logic [6:0]  cmd_opmode, dsp_opmode;
    logic [3:0]  cmd_alumode, dsp_alumode, bram1_we;
    logic [9:0]  bram0_addr, bram1_raddr, bram1_waddr;

    // ---- DUT B (longer pipeline) ----
    logic        cmd_valid_b, cmd_ready_b, abort_b, busy_b, done_b;
    logic [9:0]  cmd_src0_b, cmd_src1_b, cmd_dst_b;
    logic [7:0]  cmd_len_b;
    logic [4:0]  cmd_inmode_b, dsp_inmode_b;
    logic [6:0]  cmd_opmode_b, dsp_opmode_b;
    logic [3:0]  cmd_alumode_b, dsp_alumode_b, bram1_we_b;
    logic [9:0]  bram0_addr_b, bram1_raddr_b, bram1_waddr_b;

    bram_dsp_seq_ctrl u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_inmode(cmd_inmode), .cmd_opmode(cmd_opmode), .cmd_alumode(cmd_alumode),
        .abort(abort), .busy(busy), .done(done),
        .bram0_addr(bram0_addr), .bram1_raddr(bram1_raddr),
        .bram1_waddr(bram1_waddr), .bram1_we(bram1_we),
        .dsp_inmode(dsp_inmode), .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode)
    );

    bram_dsp_seq_ctrl #(.BRAM_RD_LAT(2), .DSP_LAT(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_src0(cmd_src0_b), .cmd_src1(cmd_src1_b), .cmd_dst(cmd_dst_b), .cmd_len(cmd_len_b),
        .cmd_inmode(cmd_inmode_b), .cmd_opmode(cmd_opmode_b), .cmd_alumode(cmd_alumode_b),
        .abort(abort_b), .busy(busy_b), .done(done_b),
        .bram0_addr(bram0_addr_b), .bram1_raddr(bram1_raddr_b),
        .bram1_waddr(bram1_waddr_b), .bram1_we(bram1_we_b),
        .dsp_inmode(dsp_inmode_b), .dsp_opmode(dsp_opmode_b), .dsp_alumode(dsp_alumode_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one command on DUT A and check every cycle through the return to
    // IDLE against the cycle-by-cycle timeline implied by PIPE_LAT.
    task automatic run_cmd(input logic [9:0] src0, input logic [9:0] src1,
                           input logic [9:0] dst,  input int len,
                           input logic [4:0] inm,  input logic [6:0] opm,
                           input logic [3:0] alm,  input logic abort_on_accept);
        int         total;
        logic       exp_we;
        logic [9:0] exp_a;
        cmd_src0 = src0; cmd_src1 = src1; cmd_dst = dst; cmd_len = 8'(len);
        cmd_inmode = inm; cmd_opmode = opm; cmd_alumode = alm;
        cmd_valid = 1'b1;
        abort = abort_on_accept;
        check_eq("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        tick;
        cmd_valid = 1'b0;
        abort = 1'b0;
        total = (len == 0) ? 1 : 1 + len + PL;
        for (int c = 1; c <= total + 1; c++) begin
            if (c == 1) begin
                check_eq("dsp_inmode",  {27'd0, dsp_inmode},  {27'd0, inm});
                check_eq("dsp_opmode",  {25'd0, dsp_opmode},  {25'd0, opm});
                check_eq("dsp_alumode", {28'd0, dsp_alumode}, {28'd0, alm});
            end
            if (len != 0) begin
                exp_a = (c <= len) ? src0 + 10'(c - 1) : src0 + 10'(len - 1);
                check_eq($sformatf("bram0_addr c%0d", c), {22'd0, bram0_addr}, {22'd0, exp_a});
                exp_a = (c <= len) ? src1 + 10'(c - 1) : src1 + 10'(len - 1);
                check_eq($sformatf("bram1_raddr c%0d", c), {22'd0, bram1_raddr}, {22'd0, exp_a});
            end
            exp_we = (len != 0) && (c >= 1 + PL) && (c <= len + PL);
            exp_a  = exp_we ? dst + 10'(c - 1 - PL) : 10'd0;
            check_eq($sformatf("bram1_we c%0d", c), {28'd0, bram1_we}, exp_we ? 32'hF : 32'h0);
            check_eq($sformatf("bram1_waddr c%0d", c), {22'd0, bram1_waddr}, {22'd0, exp_a});
            check_eq($sformatf("done c%0d", c), {31'd0, done}, {31'd0, (c == total)});
            check_eq($sformatf("busy c%0d", c), {31'd0, busy}, {31'd0, (len != 0 && c < total)});
            check_eq($sformatf("cmd_ready c%0d", c), {31'd0, cmd_ready}, {31'd0, (c == total + 1)});
            if (c <= total) tick;
        end
        $display("[TB] cmd src0=%03h src1=%03h dst=%03h len=%0d abort_at_accept=%0b checked",
                 src0, src1, dst, len, abort_on_accept);
    endtask

    // Safety net: no run may hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int waited;

        cmd_valid = 0; abort = 0; cmd_src0 = 0; cmd_src1 = 0; cmd_dst = 0; cmd_len = 0;
        cmd_inmode = 0; cmd_opmode = 0; cmd_alumode = 0;
        cmd_valid_b = 0; abort_b = 0; cmd_src0_b = 0; cmd_src1_b = 0; cmd_dst_b = 0; cmd_len_b = 0;
        cmd_inmode_b = 0; cmd_opmode_b = 0; cmd_alumode_b = 0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) tick;
        reset = 1'b1;

        // ---- Reset state and idle ----
        check_eq("rst bram0_addr", {22'd0, bram0_addr}, 32'd0);
        check_eq("rst bram1_raddr", {22'd0, bram1_raddr}, 32'd0);
        check_eq("rst dsp_opmode", {25'd0, dsp_opmode}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("idle cmd_ready %0d", k), {31'd0, cmd_ready}, 32'd1);
            check_eq($sformatf("idle busy %0d", k), {31'd0, busy}, 32'd0);
            check_eq($sformatf("idle we %0d", k), {28'd0, bram1_we}, 32'd0);
            check_eq($sformatf("idle done %0d", k), {31'd0, done}, 32'd0);
            tick;
        end
        $display("[TB] reset/idle checked");

        // ---- Basic, zero-length and wrap-around commands ----
        run_cmd(10'h010, 10'h020, 10'h100, 4, INMODE_DEFAULT, OPMODE_MULT, ALUMODE_ADD, 1'b0);
        run_cmd(10'h030, 10'h040, 10'h150, 0, 5'b00101, OPMODE_MAC, ALUMODE_SUB, 1'b0);
        run_cmd(10'h3FE, 10'h3FE, 10'h3FF, 3, INMODE_DEFAULT, OPMODE_MULT, ALUMODE_ADD, 1'b0);

        // ---- Abort on the third ISSUE cycle of a len=6 command ----
        cmd_src0 = 10'h050; cmd_src1 = 10'h060; cmd_dst = 10'h070; cmd_len = 8'd6;
        cmd_valid = 1'b1;
        tick;                       // c=1
        cmd_valid = 1'b0;
        tick;                       // c=2
        tick;                       // c=3, third ISSUE cycle
        check_eq("abort busy before", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick;                       // c=4
        abort = 1'b0;
        check_eq("abort cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_eq("abort busy", {31'd0, busy}, 32'd0);
        check_eq("abort we", {28'd0, bram1_we}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick;
            check_eq($sformatf("post-abort we %0d", k), {28'd0, bram1_we}, 32'd0);
            check_eq($sformatf("post-abort done %0d", k), {31'd0, done}, 32'd0);
        end
        $display("[TB] abort at third ISSUE cycle checked");

        // Follow-up command; abort raised alongside the accept must not block it.
        run_cmd(10'h200, 10'h210, 10'h220, 1, INMODE_DEFAULT, OPMODE_MAC, ALUMODE_ADD, 1'b1);

        // ---- Longer pipeline instance: PIPE_LAT = 6, len = 2 ----
        cmd_src0_b = 10'h080; cmd_src1_b = 10'h090; cmd_dst_b = 10'h200; cmd_len_b = 8'd2;
        cmd_inmode_b = INMODE_DEFAULT; cmd_opmode_b = OPMODE_MAC; cmd_alumode_b = ALUMODE_SUB;
        cmd_valid_b = 1'b1;         // held high for the whole command
        check_eq("b ready_before_accept", {31'd0, cmd_ready_b}, 32'd1);
        tick;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) begin
                check_eq("b dsp_opmode", {25'd0, dsp_opmode_b}, {25'd0, OPMODE_MAC});
                check_eq("b dsp_alumode", {28'd0, dsp_alumode_b}, {28'd0, ALUMODE_SUB});
            end
            if (c <= 2)
                check_eq($sformatf("b bram0_addr c%0d", c), {22'd0, bram0_addr_b}, 32'h080 + 32'(c - 1));
            check_eq($sformatf("b we c%0d", c), {28'd0, bram1_we_b},
                     (c == 1 + PL_B || c == 2 + PL_B) ? 32'hF : 32'h0);
            check_eq($sformatf("b waddr c%0d", c), {22'd0, bram1_waddr_b},
                     (c == 1 + PL_B) ? 32'h200 : (c == 2 + PL_B) ? 32'h201 : 32'h0);
            check_eq($sformatf("b done c%0d", c), {31'd0, done_b}, {31'd0, (c == 3 + PL_B)});
            check_eq($sformatf("b busy c%0d", c), {31'd0, busy_b}, {31'd0, (c <= 2 + PL_B)});
            check_eq($sformatf("b cmd_ready c%0d", c), {31'd0, cmd_ready_b}, {31'd0, (c == 4 + PL_B)});
            if (c < 10) tick;
        end
        // Still-valid command is taken as soon as the block is back in IDLE.
        tick;
        cmd_valid_b = 1'b0;
        check_eq("b reaccept busy", {31'd0, busy_b}, 32'd1);
        found = 1'b0;
        waited = 0;
        for (int k = 0; k < 40; k++) begin
            if (done_b) begin
                found = 1'b1;
                break;
            end
            tick;
            waited++;
        end
        check_eq("b second done seen", {31'd0, found}, 32'd1);
        check_eq("b second done latency", 32'(waited), 32'(2 + PL_B));
        $display("[TB] long-pipeline command pair checked");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
